input_buffer: RTL and testbench

INPUT_BUFFER -- requirements
Module: input_buffer

---
 rtl/input_buffer.sv | 66 ++++++
 tb/tb_input_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// Link input buffer: DEPTH-entry first-word-fall-through flit FIFO
// with occupancy count and one-cycle overflow/underflow pulses.
module input_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  full,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags come from the registered count, so acceptance uses pre-edge state
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign wr_ok    = write && !full;
    assign rd_ok    = read && !empty;
    assign Data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_ptr] <= Data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write && full;
            underflow <= read && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// Directed self-checking bench for input_buffer (DEPTH=4, 8-bit flits).
module tb_input_buffer;

    logic       clk;
    logic       rst;
    logic       write;
    logic [7:0] data_in;
    logic       full;
    logic       read;
    logic [7:0] data_out;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    input_buffer #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .Data_in   (data_in),
        .full      (full),
        .read      (read),
        .Data_out  (data_out),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        data_in = 8'h00;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        step();
        #3 rst = 1'b0;

        // single write then read
        step();
        write = 1'b1; data_in = 8'hA5;
        step();
        write = 1'b0;
        chk("w1_empty", empty, 0);
        chk("w1_count", count, 1);
        chk("w1_dout", data_out, 8'hA5);
        read = 1'b1;
        step();
        read = 1'b0;
        chk("r1_empty", empty, 1);
        chk("r1_count", count, 0);
        chk("r1_unf", underflow, 0);

        // fill, overflow, drain
        for (int i = 1; i <= 4; i++) begin
            write = 1'b1; data_in = 8'(i);
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        data_in = 8'h05;
        step();
        write = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 4);
        step();
        chk("ovf_clear", overflow, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_dout", data_out, 32'(i));
            read = 1'b1;
            step();
        end
        read = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_unf", underflow, 0);

        // streaming with wrap-around
        write = 1'b1; data_in = 8'h10;
        step();
        for (int i = 1; i <= 9; i++) begin
            chk("stream_dout", data_out, 32'(8'h10 + i - 1));
            data_in = 8'(8'h10 + i);
            read = 1'b1;
            step();
            chk("stream_count", count, 1);
            chk("stream_ovf", overflow, 0);
            chk("stream_unf", underflow, 0);
        end
        write = 1'b0;
        chk("stream_last", data_out, 8'h19);
        step();
        read = 1'b0;
        chk("stream_empty", empty, 1);

        // write+read while full
        for (int i = 1; i <= 4; i++) begin
            write = 1'b1; data_in = 8'(8'h20 + i);
            step();
        end
        write = 1'b0;
        chk("full2", full, 1);
        write = 1'b1; read = 1'b1; data_in = 8'h99;
        step();
        write = 1'b0; read = 1'b0;
        chk("wrf_count", count, 3);
        chk("wrf_ovf", overflow, 1);
        for (int i = 2; i <= 4; i++) begin
            chk("wrf_dout", data_out, 32'(8'h20 + i));
            read = 1'b1;
            step();
        end
        read = 1'b0;
        chk("wrf_empty", empty, 1);

        // underflow cases
        read = 1'b1;
        step();
        read = 1'b0;
        chk("unf_pulse", underflow, 1);
        chk("unf_count", count, 0);
        step();
        chk("unf_clear", underflow, 0);
        write = 1'b1; read = 1'b1; data_in = 8'h55;
        step();
        write = 1'b0; read = 1'b0;
        chk("wre_count", count, 1);
        chk("wre_unf", underflow, 1);
        chk("wre_dout", data_out, 8'h55);
        read = 1'b1;
        step();
        read = 1'b0;
        chk("wre_empty", empty, 1);

        // async reset mid-operation
        for (int i = 1; i <= 3; i++) begin
            write = 1'b1; data_in = 8'(8'h30 + i);
            step();
        end
        chk("pre_rst_count", count, 3);
        read = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_count", count, 0);
        step();
        chk("arst_hold_count", count, 0);
        chk("arst_hold_ovf", overflow, 0);
        #3 rst = 1'b0;
        write = 1'b0; read = 1'b0;
        step();
        write = 1'b1; data_in = 8'h44;
        step();
        write = 1'b0;
        chk("post_rst_count", count, 1);
        chk("post_rst_dout", data_out, 8'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
